pair_dist_sched: RTL and testbench

Hardware scheduler that runs the program-2 kernel (minimum and maximum arithmetic distance over all pairs of 32 signed 16-bit values) directly against data memory. It sits beside the processor core on the data-memory port and uses the same start/done handshake as the top-level `DUT`. It caches the operands, sequences all 496 distinct pairs through a shared distance unit, and writes Min to core[66:67] and Max to core[68:69].

---
 rtl/pds_pkg.sv | 25 ++
 rtl/pair_dist_sched_abs_dist.sv | 18 +
 rtl/pair_dist_sched.sv | 193 +++++++++++++++++++
 tb/tb_pair_dist_sched.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pds_pkg.sv
// Shared types and constants for the pair-distance scheduler.
package pds_pkg;

   localparam int PDS_NUM_VALS = 32;
   localparam int IDX_W        = 5;
   localparam int CNT_W        = 10;

   localparam logic [15:0] MIN_INIT = 16'hFFFF;
   localparam logic [15:0] MAX_INIT = 16'h0000;

   function automatic int pair_count(input int n);
      return n * (n - 1) / 2;
   endfunction

   localparam int NUM_PAIRS = pair_count(PDS_NUM_VALS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SCAN,
      ST_WRITE,
      ST_DONE
   } state_e;

endpackage

// File: rtl/pair_dist_sched_abs_dist.sv
// Combinational |a - b| for signed 16-bit operands; the 17-bit difference never overflows.
module abs_dist (
   input  logic signed [15:0] a_i,
   input  logic signed [15:0] b_i,
   output logic        [15:0] dist_o
);

   logic signed [16:0] diff;

   // Magnitude of a 17-bit difference always fits in 16 unsigned bits (max 65535).
   function automatic logic [15:0] mag17(input logic signed [16:0] x);
      return x[16] ? 16'(-x) : x[15:0];
   endfunction

   assign diff   = {a_i[15], a_i} - {b_i[15], b_i};
   assign dist_o = mag17(diff);

endmodule

// File: rtl/pair_dist_sched.sv
// Caches NUM_VALS big-endian operands, scans every distinct pair once and writes Min/Max back to memory.
module pair_dist_sched
   import pds_pkg::*;
#(
   parameter int NUM_VALS    = PDS_NUM_VALS,
   parameter int BASE_ADDR   = 0,
   parameter int RESULT_ADDR = 66
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       done,
   output logic       busy,
   output logic [7:0] mem_addr,
   input  logic [7:0] mem_rd_data,
   output logic       mem_wr_en,
   output logic [7:0] mem_wr_data,
   output logic [4:0] min_i,
   output logic [4:0] min_j,
   output logic [4:0] max_i,
   output logic [4:0] max_j
);

   localparam int N_PAIRS   = pair_count(NUM_VALS);
   localparam int LOAD_LAST = 2 * NUM_VALS;

   state_e             state_q, state_d;
   logic               start_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   pj_q, pj_d, pk_q, pk_d;
   logic               run_start;
   logic               vld_p0, vld_p1;
   logic [15:0]        dist_p0, dist_p1;
   logic [IDX_W-1:0]   pj_p1, pk_p1;
   logic [15:0]        min_q, max_q;
   logic [IDX_W-1:0]   min_i_q, min_j_q, max_i_q, max_j_q;
   logic               upd_min, upd_max;
   logic [15:0]        cache_q [NUM_VALS];
   logic               cap_en, cap_hi;
   logic [IDX_W:0]     cap_byte;
   logic [IDX_W-1:0]   cap_idx;
   logic signed [15:0] op_a, op_b;

   abs_dist u_abs_dist (
      .a_i    (op_a),
      .b_i    (op_b),
      .dist_o (dist_p0)
   );

   assign op_a = cache_q[pk_q];
   assign op_b = cache_q[pj_q];

   // Read data for the address issued at LOAD count n arrives while the count is n+1.
   assign cap_en   = (state_q == ST_LOAD) && (cnt_q != '0);
   assign cap_byte = (IDX_W + 1)'(cnt_q - 1'b1);
   assign cap_idx  = cap_byte[IDX_W:1];
   assign cap_hi   = ~cap_byte[0];

   assign upd_min = vld_p1 && (dist_p1 < min_q);
   assign upd_max = vld_p1 && (dist_p1 > max_q);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pj_d        = pj_q;
      pk_d        = pk_q;
      run_start   = 1'b0;
      vld_p0      = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      mem_addr    = 8'h00;
      mem_wr_en   = 1'b0;
      mem_wr_data = 8'h00;
      unique case (state_q)
         ST_IDLE: begin
            if (start_q && !start) begin
               state_d   = ST_LOAD;
               cnt_d     = '0;
               run_start = 1'b1;
            end
         end
         ST_LOAD: begin
            busy     = 1'b1;
            mem_addr = 8'(BASE_ADDR) + cnt_q[7:0];
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(LOAD_LAST)) begin
               state_d = ST_SCAN;
               cnt_d   = '0;
               pj_d    = '0;
               pk_d    = IDX_W'(1);
            end
         end
         ST_SCAN: begin
            // One extra count drains the registered distance of the final pair.
            busy   = 1'b1;
            vld_p0 = (cnt_q < CNT_W'(N_PAIRS));
            cnt_d  = cnt_q + 1'b1;
            if (pk_q == IDX_W'(NUM_VALS - 1)) begin
               pj_d = pj_q + 1'b1;
               pk_d = pj_q + IDX_W'(2);
            end else begin
               pk_d = pk_q + 1'b1;
            end
            if (cnt_q == CNT_W'(N_PAIRS)) begin
               state_d = ST_WRITE;
               cnt_d   = '0;
            end
         end
         ST_WRITE: begin
            busy      = 1'b1;
            mem_wr_en = 1'b1;
            mem_addr  = 8'(RESULT_ADDR) + cnt_q[7:0];
            cnt_d     = cnt_q + 1'b1;
            case (cnt_q[1:0])
               2'd0:    mem_wr_data = min_q[15:8];
               2'd1:    mem_wr_data = min_q[7:0];
               2'd2:    mem_wr_data = max_q[15:8];
               default: mem_wr_data = max_q[7:0];
            endcase
            if (cnt_q == CNT_W'(3)) begin
               state_d = ST_DONE;
               cnt_d   = '0;
            end
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         start_q <= 1'b0;
         cnt_q   <= '0;
         pj_q    <= '0;
         pk_q    <= '0;
         vld_p1  <= 1'b0;
         min_i_q <= '0;
         min_j_q <= '0;
         max_i_q <= '0;
         max_j_q <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start;
         cnt_q   <= cnt_d;
         pj_q    <= pj_d;
         pk_q    <= pk_d;
         vld_p1  <= vld_p0;
         if (run_start) begin
            min_i_q <= '0;
            min_j_q <= '0;
            max_i_q <= '0;
            max_j_q <= '0;
         end else begin
            if (upd_min) begin
               min_i_q <= pk_p1;
               min_j_q <= pj_p1;
            end
            if (upd_max) begin
               max_i_q <= pk_p1;
               max_j_q <= pj_p1;
            end
         end
      end
   end

   // p0 -> p1: distance and pair indices registered ahead of the strict compare.
   always_ff @(posedge clk) begin
      if (cap_en) begin
         if (cap_hi) cache_q[cap_idx][15:8] <= mem_rd_data;
         else        cache_q[cap_idx][7:0]  <= mem_rd_data;
      end
      dist_p1 <= dist_p0;
      pj_p1   <= pj_q;
      pk_p1   <= pk_q;
      if (run_start) begin
         min_q <= MIN_INIT;
         max_q <= MAX_INIT;
      end else begin
         if (upd_min) min_q <= dist_p1;
         if (upd_max) max_q <= dist_p1;
      end
   end

   assign min_i = min_i_q;
   assign min_j = min_j_q;
   assign max_i = max_i_q;
   assign max_j = max_j_q;

endmodule

// File: tb/tb_pair_dist_sched.sv
// Randomized scoreboard bench for pair_dist_sched with a pairwise reference model and byte memory.
module tb_pair_dist_sched;

   localparam int NV  = 32;
   localparam int RES = 66;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       done, busy;
   logic [7:0] mem_addr, mem_rd_data, mem_wr_data;
   logic       mem_wr_en;
   logic [4:0] min_i, min_j, max_i, max_j;

   logic [7:0]  mem     [256];
   logic [7:0]  exp_img [256];
   logic [15:0] exp_q [$];
   int          vals [NV];
   int          total = 0;
   int          bad   = 0;

   pair_dist_sched #(.NUM_VALS(NV), .BASE_ADDR(0), .RESULT_ADDR(RES)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .done        (done),
      .busy        (busy),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_data (mem_wr_data),
      .min_i       (min_i),
      .min_j       (min_j),
      .max_i       (max_i),
      .max_j       (max_j)
   );

   always #5 clk = ~clk;

   // Registered-read byte memory.
   always @(posedge clk) begin
      mem_rd_data <= mem[mem_addr];
      if (mem_wr_en === 1'b1) mem[mem_addr] = mem_wr_data;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Write monitor: every strobe must match the next queued byte.
   initial begin
      forever begin
         @(negedge clk);
         if (mem_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: addr=%0d data=%0h expected no write", mem_addr, mem_wr_data);
            end else begin
               chk("wr_byte", {16'h0, mem_addr, mem_wr_data}, {16'h0, exp_q.pop_front()});
            end
         end
      end
   end

   task automatic model(output int mn, output int mx, output int mni, output int mnj,
                        output int mxi, output int mxj);
      int d;
      mn = 65535; mx = 0; mni = 0; mnj = 0; mxi = 0; mxj = 0;
      for (int j = 0; j < NV - 1; j++) begin
         for (int k = j + 1; k < NV; k++) begin
            d = vals[k] - vals[j];
            if (d < 0) d = -d;
            if (d < mn) begin mn = d; mni = k; mnj = j; end
            if (d > mx) begin mx = d; mxi = k; mxj = j; end
         end
      end
   endtask

   task automatic load_image();
      logic [15:0] w;
      for (int i = 0; i < NV; i++) begin
         w = vals[i][15:0];
         mem[2*i]     = w[15:8];
         mem[2*i + 1] = w[7:0];
      end
      for (int i = 0; i < 256; i++) exp_img[i] = mem[i];
   endtask

   task automatic chk_image(input string name);
      int errs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== exp_img[i]) errs++;
      chk(name, errs, 0);
   endtask

   task automatic rand_vals();
      logic [15:0] r;
      for (int i = 0; i < NV; i++) begin
         r = 16'($urandom);
         vals[i] = $signed(r);
      end
   endtask

   task automatic do_run(input bit toggle, input string tag);
      int mn, mx, mni, mnj, mxi, mxj;
      int n;
      bit hit;
      logic prev_busy;
      load_image();
      model(mn, mx, mni, mnj, mxi, mxj);
      exp_img[RES]   = mn[15:8];
      exp_img[RES+1] = mn[7:0];
      exp_img[RES+2] = mx[15:8];
      exp_img[RES+3] = mx[7:0];
      exp_q.push_back({8'(RES),     mn[15:8]});
      exp_q.push_back({8'(RES + 1), mn[7:0]});
      exp_q.push_back({8'(RES + 2), mx[15:8]});
      exp_q.push_back({8'(RES + 3), mx[7:0]});
      @(negedge clk) start = 1'b0;
      @(posedge clk);
      n = 0; hit = 1'b0; prev_busy = 1'b0;
      while (n < 2000) begin
         @(posedge clk); #1;
         n++;
         if (toggle && n == 300) start = 1'b1;
         if (toggle && n == 304) start = 1'b0;
         if (done === 1'b1) begin hit = 1'b1; break; end
         prev_busy = busy;
      end
      if (!hit) begin
         chk({tag, "_done_timeout"}, 0, 1);
         exp_q.delete();
         start = 1'b1;
         return;
      end
      chk({tag, "_latency"}, n, 566);
      chk({tag, "_busy_edge"}, {30'h0, prev_busy, busy}, 32'h2);
      chk({tag, "_min_i"}, min_i, mni);
      chk({tag, "_min_j"}, min_j, mnj);
      chk({tag, "_max_i"}, max_i, mxi);
      chk({tag, "_max_j"}, max_j, mxj);
      chk({tag, "_wr_count"}, exp_q.size(), 0);
      exp_q.delete();
      chk_image({tag, "_mem_image"});
      repeat (4) @(posedge clk);
      #1 chk({tag, "_done_hold"}, done, 1);
      start = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_done_clear"}, done, 0);
   endtask

   task automatic abort_run();
      load_image();
      @(negedge clk) start = 1'b0;
      @(posedge clk);
      repeat (65 + 200) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_wr_en", mem_wr_en, 0);
      chk("abort_done", done, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      start = 1'b1;
      repeat (4) @(posedge clk); #1;
      chk_image("abort_mem_image");
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wr_en", mem_wr_en, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wr_data", mem_wr_data, 0);
      chk("rst_min_i", min_i, 0);
      chk("rst_min_j", min_j, 0);
      chk("rst_max_i", max_i, 0);
      chk("rst_max_j", max_j, 0);
      reset = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < NV; i++) vals[i] = i;
      do_run(1'b0, "ramp");
      for (int i = 0; i < NV; i++) vals[i] = -5;
      do_run(1'b0, "flat");
      for (int i = 0; i < NV; i++) vals[i] = 0;
      vals[0] = -32768;
      vals[NV-1] = 32767;
      do_run(1'b0, "span");
      for (int i = 0; i < NV; i++) vals[i] = i * 1000 - 15000;
      vals[3] = 100; vals[7] = 100; vals[10] = 100; vals[20] = 100;
      do_run(1'b0, "dup");
      rand_vals();
      abort_run();
      rand_vals();
      do_run(1'b0, "post_abort");
      rand_vals();
      do_run(1'b1, "toggle");
      for (int r = 0; r < 3; r++) begin
         rand_vals();
         do_run(1'b0, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
